// File: rtl/drive_stream_bridge_pkg.sv
// Shared types and helpers for the drive/free to valid/ready stream bridge.
// Holds the handshake FSM state encoding and the FIFO level-width helper.
package drive_stream_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_SPACE = 2'd1,
      FREE       = 2'd2,
      WAIT_LOW   = 2'd3
   } bridge_state_t;

   // Occupancy counters need one extra bit so a full buffer is distinguishable from an empty one.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/drive_stream_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO used as the bridge's word buffer.
// The head word is registered and reads back as zero while the buffer is empty.
module sync_fifo_fwft
   import drive_stream_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                wr_en,
   input  logic [DATA_WIDTH-1:0]               wr_data,
   input  logic                                rd_en,
   output logic [DATA_WIDTH-1:0]               rd_data,
   output logic                                empty,
   output logic                                full,
   output logic [level_width(FIFO_DEPTH)-1:0]  level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = level_width(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      rd_ptr_next;
   logic [LVL_W-1:0]      level_next;
   logic                  do_rd;
   logic                  do_wr;

   assign empty = (level == '0);
   assign full  = (level == LVL_W'(FIFO_DEPTH));
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   // Work out where the head pointer and occupancy land after this edge.
   always_comb begin
      rd_ptr_next = rd_ptr;
      level_next  = level;
      if (do_rd) begin
         rd_ptr_next = rd_ptr + PTR_W'(1);
      end
      if (do_wr && !do_rd) begin
         level_next = level + LVL_W'(1);
      end else if (!do_wr && do_rd) begin
         level_next = level - LVL_W'(1);
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (rstn && do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered head word.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr_next;
         level  <= level_next;
         if (level_next == '0) begin
            rd_data <= '0;
         end else if (do_wr && (wr_ptr == rd_ptr_next)) begin
            rd_data <= wr_data;
         end else begin
            rd_data <= mem[rd_ptr_next];
         end
      end
   end

   wr_when_full: assert property (@(posedge clk) disable iff (!rstn) !(wr_en && full && !do_rd));

endmodule

// File: rtl/drive_stream_bridge.sv
// Bridge from a 4-way mutex-merge drive/free handshake to a clocked valid/ready stream.
// Synchronises i_drive, stores each word in a FWFT buffer and acknowledges with an o_free pulse.
// Optional feature macro: DRIVE_STREAM_BRIDGE_STATS_EN adds transfer and stall counters.
module drive_stream_bridge
   import drive_stream_bridge_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FREE_CYCLES = 2
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                i_drive,
   input  logic [DATA_WIDTH-1:0]               i_data,
   output logic                                o_free,
   output logic                                o_valid,
   output logic [DATA_WIDTH-1:0]               o_data,
   input  logic                                i_ready,
   output logic [level_width(FIFO_DEPTH)-1:0]  o_level
`ifdef DRIVE_STREAM_BRIDGE_STATS_EN
   ,
   output logic [31:0]                         o_xfer_cnt,
   output logic [15:0]                         o_stall_cnt
`endif
);

   localparam int CNT_W = $clog2(FREE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev;
   logic                   sync_out;
   logic                   rise;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic                   can_write;
   logic                   wr_en;
   logic                   free_last;
   logic [CNT_W-1:0]       free_cnt;
   bridge_state_t          state;
   bridge_state_t          state_next;

   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign rise      = sync_out & ~sync_prev;
   assign can_write = ~fifo_full | (i_ready & ~fifo_empty);
   assign free_last = (free_cnt == CNT_W'(FREE_CYCLES - 1));
   assign o_free    = (state == FREE);
   assign o_valid   = ~fifo_empty;

   // Bring the asynchronous drive request into the clock domain and keep its previous value.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q    <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], i_drive};
         sync_prev <= sync_out;
      end
   end

   // Handshake state register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Times the o_free pulse; restarts from zero each time the FREE state is left.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         free_cnt <= '0;
      end else if ((state == FREE) && !free_last) begin
         free_cnt <= free_cnt + CNT_W'(1);
      end else begin
         free_cnt <= '0;
      end
   end

   // Next-state and buffer-write decisions; a same-cycle pop makes room in a full buffer.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               if (can_write) begin
                  wr_en      = 1'b1;
                  state_next = FREE;
               end else begin
                  state_next = WAIT_SPACE;
               end
            end
         end
         WAIT_SPACE: begin
            if (can_write) begin
               wr_en      = 1'b1;
               state_next = FREE;
            end
         end
         FREE: begin
            if (free_last) begin
               state_next = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!sync_out) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   sync_fifo_fwft #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_en),
      .wr_data (i_data),
      .rd_en   (i_ready),
      .rd_data (o_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (o_level)
   );

`ifdef DRIVE_STREAM_BRIDGE_STATS_EN
   // Counts stored words (wrapping) and cycles spent stalled on a full buffer (saturating).
   always_ff @(posedge clk) begin
      if (!rstn) begin
         o_xfer_cnt  <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (wr_en) begin
            o_xfer_cnt <= o_xfer_cnt + 32'd1;
         end
         if ((state == WAIT_SPACE) && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
